// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner slice.
//   DEF_*  : default parameter values, expressed in clock cycles.
//   cnt_w  : counter width helper; returns at least 1 bit even for n <= 1.
package button_conditioner_pkg;

  localparam int DEF_WIDTH          = 4;
  localparam int DEF_SAMPLE_CNT_MAX = 25000;  // 200 us at 125 MHz
  localparam int DEF_PULSE_CNT_MAX  = 150;    // ~30 ms of stable samples

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the conditioner.
//   buttons_in : raw asynchronous pins (driven by master)
//   level      : debounced pressed state, 1 = pressed
//   pulse      : one-cycle strobe on each debounced press
// Signal semantics: there is no valid/ready handshake; level is a steady
// state signal and pulse is a self-contained single-cycle enable that the
// consumer must sample on the cycle it is high.
interface button_conditioner_if
  import button_conditioner_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] buttons_in;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] pulse;

  modport master (output buttons_in, input level, input pulse);
  modport slave  (input buttons_in, output level, output pulse);

endinterface

// File: rtl/button_conditioner_synchronizer.sv
// Two-flop synchronizer for asynchronous level inputs (buttons, switches).
//   clk    : destination clock
//   rst    : asynchronous active-high reset, both stages clear to 0
//   async_i: asynchronous inputs
//   sync_o : inputs brought into the clk domain, 2 cycles of latency
module button_conditioner_synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
    end
  end

  assign sync_o = s2_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: normalize polarity, synchronize, debounce with a
// shared sample tick and per-bit saturating counters, then emit a one-cycle
// pulse on each debounced press.
//   clk : system clock
//   rst : asynchronous active-high reset; outputs drop to 0 immediately
//   bus : slave side of button_conditioner_if (buttons_in in, level/pulse out)
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  localparam int TW = cnt_w(SAMPLE_CNT_MAX);
  localparam int PW = cnt_w(PULSE_CNT_MAX + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PW-1:0] CNT_SAT   = PW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] norm;
  logic [WIDTH-1:0] sync;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [PW-1:0]    cnt_q [WIDTH];
  logic [PW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev_q;

  // Polarity is fixed before synchronization so everything downstream
  // treats 1 as pressed.
  assign norm = ACTIVE_LOW ? ~bus.buttons_in : bus.buttons_in;

  button_conditioner_synchronizer #(.WIDTH(WIDTH)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(norm),
    .sync_o (sync)
  );

  // Free-running sample tick shared by all bits.
  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  // A single released sample restarts qualification; presses only advance
  // on ticks and saturate so a long hold never re-triggers.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!sync[i]) begin
        cnt_d[i] = '0;
      end else if (tick && (cnt_q[i] < CNT_SAT)) begin
        cnt_d[i] = cnt_q[i] + PW'(1);
      end
    end
  end

  always_comb begin
    level = '0;
    for (int i = 0; i < WIDTH; i++) begin
      level[i] = (cnt_q[i] == CNT_SAT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      prev_q     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      prev_q     <= level;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.level = level;
  assign bus.pulse = level & ~prev_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] btn;
    int           hold;
    logic [W-1:0] exp_level;
    logic [W-1:0] exp_pulse;  // bit set = exactly one pulse during the hold
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  button_conditioner_if #(.WIDTH(W)) bus ();

  button_conditioner #(
    .WIDTH         (W),
    .ACTIVE_LOW    (1'b0),
    .SAMPLE_CNT_MAX(4),
    .PULSE_CNT_MAX (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  int           pcnt [W];
  logic [W-1:0] lv, pl, last_lv;
  vec_t         vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) pcnt[i] = 0;
  endtask

  // One clock cycle; outputs sampled on the falling edge. Pulse must mark
  // exactly the first cycle of each observed level rise.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    lv = bus.level;
    pl = bus.pulse;
    check("pulse_edge", 32'(pl), 32'(lv & ~last_lv));
    for (int i = 0; i < W; i++) if (pl[i]) pcnt[i]++;
    last_lv = lv;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- test ----------------
  initial begin
    int   first_k;
    int   drops;
    int   seen1;
    logic [W-1:0] first_pulse;

    vecs[0] = '{btn: 4'b0000, hold: 20, exp_level: 4'b0000, exp_pulse: 4'b0000};
    vecs[1] = '{btn: 4'b0001, hold: 30, exp_level: 4'b0001, exp_pulse: 4'b0001};
    vecs[2] = '{btn: 4'b0001, hold: 20, exp_level: 4'b0001, exp_pulse: 4'b0000};
    vecs[3] = '{btn: 4'b0000, hold: 10, exp_level: 4'b0000, exp_pulse: 4'b0000};
    vecs[4] = '{btn: 4'b1100, hold: 30, exp_level: 4'b1100, exp_pulse: 4'b1100};
    vecs[5] = '{btn: 4'b1111, hold: 30, exp_level: 4'b1111, exp_pulse: 4'b0011};
    vecs[6] = '{btn: 4'b0110, hold: 10, exp_level: 4'b0110, exp_pulse: 4'b0000};
    vecs[7] = '{btn: 4'b0000, hold: 10, exp_level: 4'b0000, exp_pulse: 4'b0000};

    bus.buttons_in = '0;
    last_lv = '0;
    clear_counts();

    // Reset state, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset_level", 32'(bus.level), 32'h0);
    check("reset_pulse", 32'(bus.pulse), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven steady-state vectors.
    for (int v = 0; v < 8; v++) begin
      bus.buttons_in = vecs[v].btn;
      clear_counts();
      steps(vecs[v].hold);
      check($sformatf("vec%0d_level", v), 32'(lv), 32'(vecs[v].exp_level));
      for (int i = 0; i < W; i++)
        check($sformatf("vec%0d_pulses_b%0d", v, i), pcnt[i], vecs[v].exp_pulse[i] ? 1 : 0);
    end

    // Clean press with latency window, then hold to 100 cycles.
    clear_counts();
    bus.buttons_in = 4'b0001;
    first_k = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first_k == 0 && lv[0]) first_k = k;
    end
    check("press_latency_in_window", 32'((first_k >= 11) && (first_k <= 14)), 32'd1);
    steps(80);
    check("press_pulses", pcnt[0], 1);
    check("press_level", 32'(lv), 32'h1);

    // Release: level falls exactly 3 cycles after the pin, no pulse.
    clear_counts();
    bus.buttons_in = 4'b0000;
    step(); check("release_c1", 32'(lv[0]), 32'd1);
    step(); check("release_c2", 32'(lv[0]), 32'd1);
    step(); check("release_c3", 32'(lv[0]), 32'd0);
    steps(5);
    check("release_pulses", pcnt[0], 0);

    // Bounce rejection on bit1: 5 cycles high, 5 low, for 60 cycles.
    clear_counts();
    seen1 = 0;
    for (int c = 0; c < 60; c++) begin
      bus.buttons_in = ((c / 5) % 2 == 0) ? 4'b0010 : 4'b0000;
      step();
      if (lv[1]) seen1++;
    end
    bus.buttons_in = '0;
    check("bounce_level_cycles", seen1, 0);
    check("bounce_pulses", pcnt[1], 0);
    steps(5);

    // Simultaneous press of bits 2 and 3.
    clear_counts();
    bus.buttons_in = 4'b1100;
    first_pulse = '0;
    for (int k = 0; k < 20 && first_pulse == '0; k++) begin
      step();
      first_pulse = pl;
    end
    check("simul_first_pulse", 32'(first_pulse), 32'hC);
    steps(20);
    check("simul_pulses_b2", pcnt[2], 1);
    check("simul_pulses_b3", pcnt[3], 1);
    bus.buttons_in = '0;
    steps(6);

    // Reset while bit0 is qualified and held.
    bus.buttons_in = 4'b0001;
    steps(20);
    check("pre_reset_level", 32'(lv), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("midreset_level", 32'(bus.level), 32'h0);
    check("midreset_pulse", 32'(bus.pulse), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("held_reset_level", 32'(bus.level), 32'h0);
    rst = 1'b0;
    last_lv = '0;
    clear_counts();
    steps(40);
    check("post_reset_pulses", pcnt[0], 1);
    check("post_reset_level", 32'(lv), 32'h1);

    // Long hold: one pulse, level never drops once up.
    bus.buttons_in = '0;
    steps(5);
    clear_counts();
    bus.buttons_in = 4'b0001;
    drops = 0;
    seen1 = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (lv[0]) seen1 = 1;
      else if (seen1 != 0) drops++;
    end
    check("long_hold_pulses", pcnt[0], 1);
    check("long_hold_drops", drops, 0);
    check("long_hold_level", 32'(lv), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
